// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. Oversamples RX_IN at Prescale x bit rate,
//                takes a 2-of-3 majority vote around each bit centre and
//                delivers LSB-first data with a one-cycle valid strobe and
//                parity / stop error pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BCW-1:0]            c_last_bit = BCW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] c_presc_8  = PRESCALE_WIDTH'(8);
    localparam logic [PRESCALE_WIDTH-1:0] c_presc_16 = PRESCALE_WIDTH'(16);
    localparam logic [PRESCALE_WIDTH-1:0] c_presc_32 = PRESCALE_WIDTH'(32);
    localparam logic [PRESCALE_WIDTH-1:0] c_one      = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] c_two      = PRESCALE_WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                      r_state;
    logic [PRESCALE_WIDTH-1:0]   r_edge_cnt;
    logic [BCW-1:0]              r_bit_cnt;
    logic [PRESCALE_WIDTH-1:0]   r_prescale;
    logic                        r_par_en;
    logic                        r_par_typ;
    logic                        r_par_fail;
    logic [2:0]                  r_smp;
    logic [DATA_WIDTH-1:0]       r_shift;
    logic [DATA_WIDTH-1:0]       r_p_data;
    logic                        r_data_valid;
    logic                        r_par_err;
    logic                        r_stp_err;

    logic [PRESCALE_WIDTH-1:0]   w_presc_legal;
    logic [PRESCALE_WIDTH-1:0]   w_last;
    logic [PRESCALE_WIDTH-1:0]   w_half;
    logic [PRESCALE_WIDTH-1:0]   w_smp_lo;
    logic [PRESCALE_WIDTH-1:0]   w_smp_hi;
    logic [PRESCALE_WIDTH-1:0]   w_eval;
    logic                        w_bit_end;
    logic                        w_maj;
    logic                        w_par_exp;

    // Unsupported ratios fall back to 8 so the counters always stay in range
    assign w_presc_legal = ((Prescale == c_presc_16) || (Prescale == c_presc_32))
                           ? Prescale : c_presc_8;

    // Edge positions within one bit period, derived from the latched ratio
    assign w_last    = r_prescale - c_one;
    assign w_half    = r_prescale >> 1;
    assign w_smp_lo  = w_half - c_one;
    assign w_smp_hi  = w_half + c_one;
    // Stop is judged one cycle after its last sample has been registered
    assign w_eval    = w_half + c_two;
    assign w_bit_end = (r_edge_cnt == w_last);

    assign w_maj     = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
    assign w_par_exp = (^r_shift) ^ r_par_typ;

    // Receive FSM: bit timing, majority sampling, shifting and result pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_prescale   <= c_presc_8;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_par_fail   <= 1'b0;
            r_smp        <= '0;
            r_shift      <= '0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;

            if (r_state != S_IDLE) begin
                if (r_edge_cnt == w_smp_lo) r_smp[0] <= RX_IN;
                if (r_edge_cnt == w_half)   r_smp[1] <= RX_IN;
                if (r_edge_cnt == w_smp_hi) r_smp[2] <= RX_IN;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (!RX_IN) begin
                        // This cycle is edge 0 of the start bit
                        r_state    <= S_START;
                        r_edge_cnt <= c_one;
                        r_bit_cnt  <= '0;
                        r_par_fail <= 1'b0;
                        r_prescale <= w_presc_legal;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_edge_cnt <= '0;
                        // A start bit that votes high was only a line glitch
                        r_state    <= w_maj ? S_IDLE : S_DATA;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + c_one;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_edge_cnt <= '0;
                        r_shift    <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_edge_cnt <= r_edge_cnt + c_one;
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_edge_cnt <= '0;
                        r_state    <= S_STOP;
                        if (w_maj != w_par_exp) r_par_fail <= 1'b1;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + c_one;
                    end
                end

                S_STOP: begin
                    if (r_edge_cnt == w_eval) begin
                        // Leave early so an immediately following frame is caught
                        r_edge_cnt <= '0;
                        r_state    <= S_IDLE;
                        r_stp_err  <= ~w_maj;
                        r_par_err  <= r_par_fail;
                        if (w_maj && !r_par_fail) begin
                            r_data_valid <= 1'b1;
                            r_p_data     <= r_shift;
                        end
                    end else begin
                        r_edge_cnt <= r_edge_cnt + c_one;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_edge_cnt <= '0;
                end
            endcase
        end
    end

    assign P_DATA     = r_p_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       CLK      = 1'b0;
    logic       RST      = 1'b1;
    logic       RX_IN    = 1'b1;
    logic       PAR_EN   = 1'b0;
    logic       PAR_TYP  = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int dv_n = 0, pe_n = 0, se_n = 0;
    int dv_cyc = 0, pe_cyc = 0, se_cyc = 0;
    int s_dv = 0, s_pe = 0, s_se = 0;
    logic [7:0] dv_q[$];

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK = ~CLK;

    // Cycle index: value seen at a negedge equals the index of the preceding posedge
    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse monitor, sampled away from the active edge
    always @(negedge CLK) begin
        if (data_valid) begin
            dv_n   = dv_n + 1;
            dv_cyc = cyc;
            dv_q.push_back(P_DATA);
        end
        if (par_err) begin
            pe_n   = pe_n + 1;
            pe_cyc = cyc;
        end
        if (stp_err) begin
            se_n   = se_n + 1;
            se_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_dv = dv_n;
        s_pe = pe_n;
        s_se = se_n;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    // Drive one frame cycle by cycle; glitch = frame-relative cycle to invert (-1: none)
    task automatic send_frame(input logic [7:0] data, input int p, input bit par_en,
                              input bit par_bit, input bit stop_bit, input int glitch,
                              output int t0);
        int  nb;
        logic v;
        nb = par_en ? 11 : 10;
        t0 = 0;
        for (int b = 0; b < nb; b++) begin
            if (b == 0)                   v = 1'b0;
            else if (b <= 8)              v = data[b-1];
            else if (par_en && (b == 9))  v = par_bit;
            else                          v = stop_bit;
            for (int e = 0; e < p; e++) begin
                @(negedge CLK);
                if ((b == 0) && (e == 0)) t0 = cyc + 1;
                RX_IN = v ^ ((b * p + e) == glitch);
            end
        end
    endtask

    // Compare pulse counts since the last snapshot, pulse latencies and P_DATA
    task automatic check_result(input string tag, input int t0, input int e_dv,
                                input int e_pe, input int e_se, input int e_lat,
                                input logic [7:0] e_data);
        chk({tag, "_dv_cnt"}, 32'(dv_n - s_dv), 32'(e_dv));
        chk({tag, "_pe_cnt"}, 32'(pe_n - s_pe), 32'(e_pe));
        chk({tag, "_se_cnt"}, 32'(se_n - s_se), 32'(e_se));
        if (e_dv != 0) chk({tag, "_dv_lat"}, 32'(dv_cyc - t0), 32'(e_lat));
        if (e_pe != 0) chk({tag, "_pe_lat"}, 32'(pe_cyc - t0), 32'(e_lat));
        if (e_se != 0) chk({tag, "_se_lat"}, 32'(se_cyc - t0), 32'(e_lat));
        chk({tag, "_pdata"}, 32'(P_DATA), {24'd0, e_data});
        snap();
    endtask

    initial begin
        int t0, t1;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_pdata", 32'(P_DATA), 32'h0);
        chk("rst_dv",    32'(data_valid), 32'h0);
        chk("rst_pe",    32'(par_err), 32'h0);
        chk("rst_se",    32'(stp_err), 32'h0);
        RST = 1'b0;
        idle(4);
        snap();

        // P=8, no parity, 0xA5
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, t0);
        idle(16);
        check_result("t1_a5", t0, 1, 0, 0, 78, 8'hA5);

        // Unsupported prescale 12 behaves as 8
        Prescale = 6'd12;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1, t0);
        idle(16);
        check_result("t1_p12", t0, 1, 0, 0, 78, 8'h81);

        // P=16, even parity, 0x3C: correct parity bit 0, then wrong bit 1
        Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1, t0);
        idle(24);
        check_result("t2_ok", t0, 1, 0, 0, 170, 8'h3C);
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1, t0);
        idle(24);
        check_result("t2_perr", t0, 0, 1, 0, 170, 8'h3C);

        // P=8, odd parity, 0x00: stop low; then stop low plus wrong parity
        Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        send_frame(8'h00, 8, 1'b1, 1'b1, 1'b0, -1, t0);
        idle(24);
        check_result("t3_serr", t0, 0, 0, 1, 86, 8'h3C);
        send_frame(8'h00, 8, 1'b1, 1'b0, 1'b0, -1, t0);
        idle(24);
        check_result("t3_both", t0, 0, 1, 1, 86, 8'h3C);

        // Short low pulse rejected as start glitch, then 0x5A received
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            RX_IN = 1'b0;
        end
        idle(16);
        check_result("t4_glitch", 0, 0, 0, 0, 0, 8'h3C);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1, t0);
        idle(16);
        check_result("t4_5a", t0, 1, 0, 0, 78, 8'h5A);

        // P=32 back-to-back 0x12, 0x34
        Prescale = 6'd32;
        dv_q.delete();
        send_frame(8'h12, 32, 1'b0, 1'b0, 1'b1, -1, t0);
        send_frame(8'h34, 32, 1'b0, 1'b0, 1'b1, -1, t1);
        idle(40);
        chk("t5_dv_cnt", 32'(dv_n - s_dv), 32'd2);
        chk("t5_q_size", 32'(dv_q.size()), 32'd2);
        if (dv_q.size() > 1) begin
            chk("t5_word0", 32'(dv_q[0]), 32'h12);
            chk("t5_word1", 32'(dv_q[1]), 32'h34);
        end
        chk("t5_gap",    32'(t1 - t0), 32'd320);
        chk("t5_lat1",   32'(dv_cyc - t1), 32'd306);
        chk("t5_pdata",  32'(P_DATA), 32'h34);
        snap();

        // Reset during data bit 4 of 0xF3 (remaining bits high)
        Prescale = 6'd8;
        fork
            begin
                send_frame(8'hF3, 8, 1'b0, 1'b0, 1'b1, -1, t0);
            end
            begin
                repeat (44) @(negedge CLK);
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
                chk("t6_rst_pdata", 32'(P_DATA), 32'h0);
                chk("t6_rst_dv",    32'(data_valid), 32'h0);
                chk("t6_rst_pe",    32'(par_err), 32'h0);
                chk("t6_rst_se",    32'(stp_err), 32'h0);
            end
        join
        idle(24);
        check_result("t6_quiet", 0, 0, 0, 0, 0, 8'h00);

        // 0xFF with a one-cycle low glitch at edge P/2 of data bit 2
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 3 * 8 + 4, t0);
        idle(16);
        check_result("t6_ff", t0, 1, 0, 0, 78, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive path, the counterpart of the UART TX serializer. It oversamples RX_IN at Prescale× the bit rate and majority-votes the three samples around each bit centre. The frame is start bit, then DATA_WIDTH bits LSB-first, then an optional parity bit, then one stop bit. It delivers parallel data with a one-cycle valid strobe plus parity and stop error pulses to the system side.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_WIDTH, 6, width of the Prescale port

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
RX_IN  input  1  serial line; idle high; already synchronized to CLK upstream
PAR_EN  input  1  1 = parity bit present after the data bits
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32
P_DATA  output  DATA_WIDTH  last correctly received word
data_valid  output  1  one-cycle pulse when a new word is present on P_DATA
par_err  output  1  one-cycle pulse: parity mismatch
stp_err  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (RST=1 at a CLK edge) forces: FSM to IDLE; P_DATA=0; data_valid, par_err and stp_err all 0; counters and shift register cleared. This also applies mid-frame; the partial frame is discarded without error pulses.
- Configuration latch: PAR_EN, PAR_TYP and Prescale are captured on the start-detect cycle and held constant for the whole frame. Any Prescale value other than 8, 16 or 32 is treated as 8.
- Counters: edge_cnt runs 0..P-1 within each bit period, where P is the latched prescale. bit_cnt counts data bits 0..DATA_WIDTH-1.
- Start-detect cycle: the first cycle in IDLE where RX_IN=0. This is cycle 0, and it counts as edge 0 of the start bit.
- Sampling: RX_IN is captured on edges P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority of these samples.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: on start detect.
- START, at edge P-1: if majority=1 (glitch), go to IDLE with no pulses; otherwise go to DATA.
- DATA: the majority value shifts in LSB-first. After bit DATA_WIDTH-1 ends at edge P-1, go to PARITY if PAR_EN=1, else to STOP.
- PARITY: the sampled bit is compared with the XOR of the data bits, inverted when PAR_TYP=1. A mismatch sets an internal parity-fail flag. Go to STOP at edge P-1.
- STOP: the frame is evaluated in the cycle after edge P/2+1; the FSM enters IDLE in that same cycle. It does not wait for edge P-1, so back-to-back frames are tolerated.
- Outputs at stop evaluation, all registered and asserted for exactly one cycle:
  - Stop majority = 1 and no parity fail: data_valid=1 and P_DATA is updated.
  - Parity fail: par_err=1.
  - Stop majority = 0: stp_err=1.
  - par_err and stp_err may assert together. data_valid=0 whenever either error is present.
  - P_DATA holds its previous value on errored frames and between frames.
- Latency from cycle 0 to the output pulse is (1 + DATA_WIDTH + PAR_EN)·P + P/2 + 2 cycles.
  - DATA_WIDTH=8, P=8, no parity: 78 cycles.
  - DATA_WIDTH=8, P=8, with parity: 86 cycles.
  - DATA_WIDTH=8, P=16, no parity: 154 cycles.
- Next frame: a low RX_IN detected in or after the output cycle starts a new frame immediately. RX_IN held low in IDLE after a stop error re-triggers start detection each time the FSM is in IDLE.
- Single-cycle line glitches: a glitch on one of the three samples is outvoted and has no effect.

Test Plan:
1. P=8, PAR_EN=0, frame 0xA5 sent LSB-first at 8 cycles/bit -> P_DATA=0xA5 and a single data_valid pulse at cycle 78; par_err=stp_err=0.
2. P=16, PAR_EN=1, PAR_TYP=0, data 0x3C with correct parity bit 0 -> data_valid at cycle 170, P_DATA=0x3C. Same frame with parity bit 1 -> par_err pulse at cycle 170, no data_valid, P_DATA unchanged.
3. P=8, odd parity, data 0x00 with stop bit driven 0 -> stp_err pulse at cycle 86 and no data_valid. Repeat with a wrong parity bit as well -> par_err and stp_err both pulse in the same cycle.
4. RX_IN low for 3 cycles then high (P=8) -> FSM back to IDLE at end of start bit; no pulses; a valid frame 0x5A sent next is received correctly.
5. Two back-to-back frames 0x12, 0x34 (P=32, no parity, no inter-frame gap) -> two data_valid pulses; P_DATA=0x12 then 0x34.
6. RST=1 for one cycle in the middle of data bit 4 -> all outputs 0 the next cycle, no pulses. A following frame 0xFF is received correctly; a single-cycle low glitch at edge P/2 of data bit 2 does not alter the received value.
